// File: rtl/ahb_lite_xbar1n.sv
// Single-master, N-slave AHB-Lite interconnect. It decodes fixed-size address
// regions, muxes the data-phase response from the slave selected in the address
// phase, and includes a default slave that returns ERROR for unmapped addresses.
// A wait-state watchdog aborts a hung slave transfer with ERROR.
module ahb_lite_xbar1n #(
    parameter int unsigned       NUM_SLAVES  = 4,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       REGION_BITS = 12,
    parameter int unsigned       TIMEOUT     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_W-1:0]            haddr_i,
    input  logic [1:0]                   htrans_i,
    input  logic                         hwrite_i,
    output logic [DATA_W-1:0]            hrdata_o,
    output logic                         hready_o,
    output logic                         hresp_o,
    output logic [NUM_SLAVES-1:0]        hsel_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_hrdata_i,
    input  logic [NUM_SLAVES-1:0]        s_hreadyout_i,
    input  logic [NUM_SLAVES-1:0]        s_hresp_i,
    output logic                         timeout_irq_o
);

    localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   dsel_q;
    logic              dact_q, ddef_q;
    logic [7:0]        wcnt_q, wcnt_d;

    logic              borrow;
    logic [ADDR_W-1:0] off, idx;
    logic              mapped;
    logic              def_enter;
    logic              wdog_fire;
    logic [DATA_W-1:0] slv_rdata;
    logic              slv_ready, slv_resp;

    // hwrite goes straight to the slaves outside this block.
    logic unused_hwrite;
    assign unused_hwrite = hwrite_i;

    // Address decode: the borrow flags addresses below the base, so a wrapped
    // offset can never alias into a valid region index.
    always_comb begin
        {borrow, off} = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
        idx           = off >> REGION_BITS;
        mapped        = ~borrow && (idx < ADDR_W'(NUM_SLAVES));
        hsel_o        = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (mapped && (idx == ADDR_W'(i))) begin
                hsel_o[i] = 1'b1;
            end
        end
    end

    // Data-phase select registers; they advance only when the bus completes a transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dsel_q <= '0;
            dact_q <= 1'b0;
            ddef_q <= 1'b0;
        end else if (hready_o) begin
            dsel_q <= idx[IdxW-1:0];
            dact_q <= htrans_i[1] & mapped;
            ddef_q <= htrans_i[1] & ~mapped;
        end
    end

    // Pick the response of the slave that owns the current data phase.
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q == IdxW'(i)) begin
                slv_rdata = s_hrdata_i[i*DATA_W +: DATA_W];
                slv_ready = s_hreadyout_i[i];
                slv_resp  = s_hresp_i[i];
            end
        end
    end

    // Response mux: the error FSM takes priority over the slave it replaces.
    always_comb begin
        hready_o = 1'b1;
        hresp_o  = 1'b0;
        hrdata_o = '0;
        if (state_q == StErr1) begin
            hready_o = 1'b0;
            hresp_o  = 1'b1;
        end else if (state_q == StErr2) begin
            hready_o = 1'b1;
            hresp_o  = 1'b1;
        end else if (dact_q) begin
            hready_o = slv_ready;
            hresp_o  = slv_resp;
            hrdata_o = slv_rdata;
        end
    end

    assign def_enter     = hready_o & htrans_i[1] & ~mapped;
    assign wdog_fire     = (state_q == StIdle) & dact_q & ~slv_ready &
                           (wcnt_q == 8'(TIMEOUT - 1));
    assign timeout_irq_o = wdog_fire;

    // Wait counter: counts consecutive stalled cycles of a mapped data phase.
    always_comb begin
        wcnt_d = wcnt_q;
        if (hready_o) begin
            wcnt_d = '0;
        end else if (dact_q && !slv_ready) begin
            wcnt_d = wcnt_q + 8'd1;
        end
    end

    // Default-slave / abort FSM next state. An unmapped NONSEQ accepted during
    // ERR2 starts a fresh ERROR response instead of returning to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (def_enter || wdog_fire) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = def_enter ? StErr1 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM and watchdog state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_xbar1n.sv
// Directed bench for ahb_lite_xbar1n with a transfer-level reference model.
module tb_ahb_lite_xbar1n;

    localparam longint BASE    = 0;
    localparam longint REGION  = 4096;
    localparam int     NS      = 4;
    localparam int     TIMEOUT = 16;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  haddr = 32'h0000_1004;
    logic [1:0]   htrans = IDLE;
    logic         hwrite = 1'b0;
    logic [127:0] s_hrdata = {32'h3333_0003, 32'h2222_0002, 32'hCAFE_F00D, 32'h1111_0000};
    logic [3:0]   s_hreadyout = 4'hF;
    logic [3:0]   s_hresp = 4'h0;
    logic [31:0]  hrdata;
    logic         hready, hresp, timeout_irq;
    logic [3:0]   hsel;

    int checks = 0;
    int errors = 0;

    // Model state: kind 0 = no transfer, 1 = mapped slave, 2 = unmapped.
    int m_kind = 0, m_slv = 0, m_cyc = 0, m_abort = -1;
    int n_kind = 0, n_slv = 0, n_cyc = 0, n_abort = -1;

    ahb_lite_xbar1n dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .haddr_i       (haddr),
        .htrans_i      (htrans),
        .hwrite_i      (hwrite),
        .hrdata_o      (hrdata),
        .hready_o      (hready),
        .hresp_o       (hresp),
        .hsel_o        (hsel),
        .s_hrdata_i    (s_hrdata),
        .s_hreadyout_i (s_hreadyout),
        .s_hresp_i     (s_hresp),
        .timeout_irq_o (timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Region index of an address, or -1 when it falls outside every slave.
    function automatic int region_of(input logic [31:0] a);
        longint off;
        off = longint'({32'b0, a}) - BASE;
        if (off < 0) return -1;
        if (off / REGION >= NS) return -1;
        return int'(off / REGION);
    endfunction

    function automatic logic [3:0] exp_hsel(input logic [31:0] a);
        logic [3:0] v;
        int r;
        v = '0;
        r = region_of(a);
        if (r >= 0) v[r] = 1'b1;
        return v;
    endfunction

    task automatic check_cycle();
        logic        e_rdy, e_rsp, e_irq;
        logic [31:0] e_rd;
        int          ab, r;
        e_rdy = 1'b1;
        e_rsp = 1'b0;
        e_irq = 1'b0;
        e_rd  = '0;
        ab    = m_abort;
        if (m_kind == 1) begin
            if (m_abort >= 0) begin
                e_rsp = 1'b1;
                e_rdy = (m_cyc == m_abort + 2);
            end else begin
                e_rdy = s_hreadyout[m_slv];
                e_rsp = s_hresp[m_slv];
                e_rd  = s_hrdata[m_slv*32 +: 32];
                if (!e_rdy && m_cyc == TIMEOUT - 1) begin
                    e_irq = 1'b1;
                    ab    = m_cyc;
                end
            end
        end else if (m_kind == 2) begin
            e_rsp = 1'b1;
            e_rdy = (m_cyc >= 1);
        end
        chk("model_hready", {63'b0, hready}, {63'b0, e_rdy});
        chk("model_hresp", {63'b0, hresp}, {63'b0, e_rsp});
        chk("model_hrdata", {32'b0, hrdata}, {32'b0, e_rd});
        chk("model_irq", {63'b0, timeout_irq}, {63'b0, e_irq});
        chk("model_hsel", {60'b0, hsel}, {60'b0, exp_hsel(haddr)});
        if (e_rdy) begin
            r       = region_of(haddr);
            n_cyc   = 0;
            n_abort = -1;
            n_slv   = (r < 0) ? 0 : r;
            n_kind  = !htrans[1] ? 0 : ((r < 0) ? 2 : 1);
        end else begin
            n_kind  = m_kind;
            n_slv   = m_slv;
            n_cyc   = m_cyc + 1;
            n_abort = ab;
        end
    endtask

    always @(negedge clk) check_cycle();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind  <= 0;
            m_slv   <= 0;
            m_cyc   <= 0;
            m_abort <= -1;
        end else begin
            m_kind  <= n_kind;
            m_slv   <= n_slv;
            m_cyc   <= n_cyc;
            m_abort <= n_abort;
        end
    end

    task automatic drive(input logic [31:0] a, input logic [1:0] t,
                         input logic [3:0] rdy, input logic [3:0] rsp);
        haddr       = a;
        htrans      = t;
        s_hreadyout = rdy;
        s_hresp     = rsp;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        chk("rst_hready", {63'b0, hready}, 64'd1);
        chk("rst_hresp", {63'b0, hresp}, 64'd0);
        chk("rst_hrdata", {32'b0, hrdata}, 64'd0);
        chk("rst_irq", {63'b0, timeout_irq}, 64'd0);
        chk("rst_hsel", {60'b0, hsel}, 64'b0010);
        next_cycle();
        rst_n = 1'b1;

        // Zero-wait read from slave 1.
        drive(32'h0000_1004, NSEQ, 4'hF, 4'h0);
        chk("s1_hsel", {60'b0, hsel}, 64'b0010);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("s1_rdata", {32'b0, hrdata}, 64'hCAFE_F00D);
        chk("s1_okay", {62'b0, hready, hresp}, 64'b10);
        next_cycle();

        // Slave 0 with two waits, slave 3 address held meanwhile.
        drive(32'h0000_0010, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0000_3000, NSEQ, 4'b1110, 4'h0);
        chk("pipe_wait1", {63'b0, hready}, 64'd0);
        chk("pipe_hsel", {60'b0, hsel}, 64'b1000);
        next_cycle();
        drive(32'h0000_3000, NSEQ, 4'b1110, 4'h0);
        chk("pipe_wait2", {63'b0, hready}, 64'd0);
        next_cycle();
        drive(32'h0000_3000, NSEQ, 4'hF, 4'h0);
        chk("pipe_s0_data", {32'b0, hrdata}, 64'h1111_0000);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("pipe_s3_data", {32'b0, hrdata}, 64'h3333_0003);
        next_cycle();

        // Unmapped NONSEQ at the first address past the last region.
        drive(32'h0000_4000, NSEQ, 4'hF, 4'h0);
        chk("unmap_hsel", {60'b0, hsel}, 64'd0);
        next_cycle();
        drive(32'h0000_4000, IDLE, 4'hF, 4'h0);
        chk("unmap_err1", {62'b0, hready, hresp}, 64'b01);
        chk("unmap_rdata", {32'b0, hrdata}, 64'd0);
        next_cycle();
        drive(32'h0000_4000, IDLE, 4'hF, 4'h0);
        chk("unmap_err2", {62'b0, hready, hresp}, 64'b11);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("idle_unmap_ok", {62'b0, hready, hresp}, 64'b10);
        next_cycle();

        // Unmapped transfer accepted during ERR2 gets its own ERROR.
        drive(32'h0000_5000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0000_5000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'hFFFF_F000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0000_3FFC, NSEQ, 4'hF, 4'h0);
        chk("b2b_err1", {62'b0, hready, hresp}, 64'b01);
        chk("top_region_hsel", {60'b0, hsel}, 64'b1000);
        next_cycle();
        drive(32'h0000_3FFC, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("top_region_data", {32'b0, hrdata}, 64'h3333_0003);
        next_cycle();

        // Slave 2 signals its own two-cycle ERROR.
        drive(32'h0000_2000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0, IDLE, 4'b1011, 4'b0100);
        chk("slv_err1", {62'b0, hready, hresp}, 64'b01);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'b0100);
        chk("slv_err2", {62'b0, hready, hresp}, 64'b11);
        next_cycle();

        // Slave 2 hangs: watchdog aborts.
        drive(32'h0000_2008, NSEQ, 4'hF, 4'h0);
        next_cycle();
        for (int k = 0; k < 18; k++) begin
            drive(32'h0, IDLE, 4'b1011, 4'h0);
            if (k == 14) chk("wdog_no_irq_early", {63'b0, timeout_irq}, 64'd0);
            if (k == 15) chk("wdog_irq", {63'b0, timeout_irq}, 64'd1);
            if (k == 16) chk("wdog_err1", {62'b0, hready, hresp}, 64'b01);
            if (k == 17) chk("wdog_err2", {62'b0, hready, hresp}, 64'b11);
            next_cycle();
        end
        drive(32'h0000_1000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("after_wdog_data", {32'b0, hrdata}, 64'hCAFE_F00D);
        next_cycle();

        // Slave ready in the same cycle the watchdog would fire: slave wins.
        drive(32'h0000_2000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            drive(32'h0, IDLE, (k == 15) ? 4'hF : 4'b1011, 4'h0);
            if (k == 15) begin
                chk("race_no_irq", {63'b0, timeout_irq}, 64'd0);
                chk("race_okay", {62'b0, hready, hresp}, 64'b10);
                chk("race_data", {32'b0, hrdata}, 64'h2222_0002);
            end
            next_cycle();
        end

        // Reset asserted during ERR1.
        drive(32'h0000_4000, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("pre_rst_err1", {62'b0, hready, hresp}, 64'b01);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_err1", {62'b0, hready, hresp}, 64'b10);
        next_cycle();
        rst_n = 1'b1;
        drive(32'h0000_1004, NSEQ, 4'hF, 4'h0);
        next_cycle();
        drive(32'h0, IDLE, 4'hF, 4'h0);
        chk("post_rst_data", {32'b0, hrdata}, 64'hCAFE_F00D);
        chk("post_rst_okay", {62'b0, hready, hresp}, 64'b10);
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
